// File: rtl/serdes_stream_cipher_if.sv
// ---------------------------------------------------------------------------
// serdes_stream_cipher_if
//  Handshake and data bundle for the serial stream cipher.
//  master : the side that feeds operands and keys (pad wrapper / testbench)
//  slave  : the cipher core
//  Signals:
//    start, in_valid, a_bit, b_bit, key_load, key  -> master to slave
//    cipher_out, cipher_vld, busy, done            -> slave to master
//  Parameter KEY_W sets the width of the key bus.
// ---------------------------------------------------------------------------
interface serdes_stream_cipher_if #(
   parameter int KEY_W = 128
);
   logic             start;
   logic             in_valid;
   logic             a_bit;
   logic             b_bit;
   logic             key_load;
   logic [KEY_W-1:0] key;
   logic             cipher_out;
   logic             cipher_vld;
   logic             busy;
   logic             done;

   modport master (
      output start, in_valid, a_bit, b_bit, key_load, key,
      input  cipher_out, cipher_vld, busy, done
   );

   modport slave (
      input  start, in_valid, a_bit, b_bit, key_load, key,
      output cipher_out, cipher_vld, busy, done
   );
endinterface

// File: rtl/serdes_stream_cipher.sv
// ---------------------------------------------------------------------------
// serdes_stream_cipher
//  Deserialises two DATA_W-bit operands A and B (MSB first, qualified by
//  in_valid), encrypts A ^ B ^ K where K is a DATA_W-bit slice of a loadable
//  key register used round-robin, then serialises the result MSB first with
//  cipher_vld and a one-cycle done pulse on the final output bit.
//  Ports:
//    clk  - rising-edge clock
//    rst  - synchronous active-high reset
//    bus  - serdes_stream_cipher_if.slave (start/in_valid/a_bit/b_bit/
//           key_load/key in; cipher_out/cipher_vld/busy/done out)
//  Optional feature macro: SERDES_PARITY_EN
//    When defined, an even-parity bit of the encrypted word follows the data
//    bits and done moves onto that parity bit.
// ---------------------------------------------------------------------------
module serdes_stream_cipher #(
   parameter int DATA_W = 8,
   parameter int KEY_W  = 128
) (
   input  logic                  clk,
   input  logic                  rst,
   serdes_stream_cipher_if.slave bus
);
   localparam int NSLICE = KEY_W / DATA_W;
   // Keep the slice index at least one bit wide so NSLICE=1 still elaborates.
   localparam int SIDX_W = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam int CNT_W  = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(DATA_W - 1);
   localparam logic [SIDX_W-1:0] LAST_SLICE = SIDX_W'(NSLICE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_ENCRYPT,
`ifdef SERDES_PARITY_EN
      S_OUTPUT,
      S_PARITY
`else
      S_OUTPUT
`endif
   } state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]   enc_q, enc_d;
   logic [KEY_W-1:0]    key_reg_q, key_reg_d;
   logic [SIDX_W-1:0]   slice_idx_q, slice_idx_d;
   logic                cipher_out_q, cipher_out_d;
   logic                cipher_vld_q, cipher_vld_d;
   logic                done_q, done_d;
`ifdef SERDES_PARITY_EN
   logic                parity_q, parity_d;
`endif

   logic [DATA_W-1:0]   key_slice;
   logic [DATA_W-1:0]   word;

   assign key_slice = key_reg_q[slice_idx_q * DATA_W +: DATA_W];
   assign word      = a_q ^ b_q ^ key_slice;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // one unassigned; an unassigned path in always_comb infers a latch.
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      bit_cnt_d    = bit_cnt_q;
      enc_d        = enc_q;
      key_reg_d    = key_reg_q;
      slice_idx_d  = slice_idx_q;
      cipher_out_d = 1'b0;
      cipher_vld_d = 1'b0;
      done_d       = 1'b0;
`ifdef SERDES_PARITY_EN
      parity_d     = parity_q;
`endif

      case (state_q)
         S_IDLE: begin
            // key_load and start may act together; the new word then sees
            // the new key at slice 0.
            if (bus.key_load) begin
               key_reg_d   = bus.key;
               slice_idx_d = '0;
            end
            if (bus.start) begin
               a_d       = '0;
               b_d       = '0;
               bit_cnt_d = '0;
               state_d   = S_SHIFT;
            end
         end

         S_SHIFT: begin
            if (bus.in_valid) begin
               a_d       = {a_q[DATA_W-2:0], bus.a_bit};
               b_d       = {b_q[DATA_W-2:0], bus.b_bit};
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = S_ENCRYPT;
               end
            end
         end

         S_ENCRYPT: begin
            enc_d       = word;
`ifdef SERDES_PARITY_EN
            parity_d    = ^word;
`endif
            slice_idx_d = (slice_idx_q == LAST_SLICE) ? '0 : slice_idx_q + SIDX_W'(1);
            bit_cnt_d   = '0;
            state_d     = S_OUTPUT;
         end

         S_OUTPUT: begin
            cipher_out_d = enc_q[DATA_W-1];
            cipher_vld_d = 1'b1;
            enc_d        = {enc_q[DATA_W-2:0], 1'b0};
            bit_cnt_d    = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == LAST_BIT) begin
`ifdef SERDES_PARITY_EN
               state_d = S_PARITY;
`else
               done_d  = 1'b1;
               state_d = S_IDLE;
`endif
            end
         end

`ifdef SERDES_PARITY_EN
         S_PARITY: begin
            cipher_out_d = parity_q;
            cipher_vld_d = 1'b1;
            done_d       = 1'b1;
            state_d      = S_IDLE;
         end
`endif

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of its peers, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         a_q          <= '0;
         b_q          <= '0;
         bit_cnt_q    <= '0;
         enc_q        <= '0;
         key_reg_q    <= '0;
         slice_idx_q  <= '0;
         cipher_out_q <= 1'b0;
         cipher_vld_q <= 1'b0;
         done_q       <= 1'b0;
`ifdef SERDES_PARITY_EN
         parity_q     <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         bit_cnt_q    <= bit_cnt_d;
         enc_q        <= enc_d;
         key_reg_q    <= key_reg_d;
         slice_idx_q  <= slice_idx_d;
         cipher_out_q <= cipher_out_d;
         cipher_vld_q <= cipher_vld_d;
         done_q       <= done_d;
`ifdef SERDES_PARITY_EN
         parity_q     <= parity_d;
`endif
      end
   end

   assign bus.cipher_out = cipher_out_q;
   assign bus.cipher_vld = cipher_vld_q;
   assign bus.done       = done_q;
   assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_serdes_stream_cipher.sv
// ---------------------------------------------------------------------------
// tb_serdes_stream_cipher
//  Self-checking bench for serdes_stream_cipher with DATA_W=8, KEY_W=32.
//  A reference model tracks the key and the round-robin slice position and
//  predicts each ciphertext word as a ^ b ^ (key >> 8*slice).
//  Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_serdes_stream_cipher;
   localparam int DATA_W = 8;
   localparam int KEY_W  = 32;
   localparam int NSLICE = KEY_W / DATA_W;
`ifdef SERDES_PARITY_EN
   localparam int NBITS  = DATA_W + 1;
`else
   localparam int NBITS  = DATA_W;
`endif

   logic clk = 1'b0;
   logic rst;

   serdes_stream_cipher_if #(.KEY_W(KEY_W)) bus ();

   serdes_stream_cipher #(
      .DATA_W (DATA_W),
      .KEY_W  (KEY_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [KEY_W-1:0] key_m = '0;
   int               idx_m = 0;

   // Runs one word. stall_mode: 0 = in_valid always high, 1 = toggle 1/0,
   // 2 = random. disturb pulses start/key_load in SHIFT and OUTPUT.
   // abort_at >= 0 asserts rst once that many output bits have been seen.
   task automatic run_word(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                           input bit do_load, input logic [KEY_W-1:0] kval,
                           input int stall_mode, input bit disturb, input int abort_at,
                           output logic [DATA_W-1:0] got);
      logic [DATA_W-1:0] exp;
      logic              exp_par;
      logic              got_par;
      int                i;
      int                guard;
      int                lat;
      int                cnt;
      got     = '0;
      got_par = 1'b0;

      @(negedge clk);
      bus.start    = 1'b1;
      bus.key_load = do_load;
      if (do_load) begin
         bus.key = kval;
         key_m   = kval;
         idx_m   = 0;
      end
      exp     = a ^ b ^ DATA_W'(key_m >> (DATA_W * idx_m));
      exp_par = ^exp;
      idx_m   = (idx_m + 1) % NSLICE;

      @(negedge clk);
      i     = 0;
      guard = 0;
      while (i < DATA_W && guard < 200) begin
         case (stall_mode)
            1:       bus.in_valid = (guard % 2 == 0);
            2:       bus.in_valid = 1'($urandom_range(0, 1));
            default: bus.in_valid = 1'b1;
         endcase
         bus.a_bit    = a[DATA_W-1-i];
         bus.b_bit    = b[DATA_W-1-i];
         bus.start    = disturb && (i == 3);
         bus.key_load = disturb && (i == 3);
         if (disturb && i == 3) bus.key = ~key_m;
         @(negedge clk);
         if (bus.in_valid) i++;
         guard++;
      end
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
      bus.key_load = 1'b0;
      checks++;
      if (i != DATA_W) begin
         errors++;
         $display("FAIL shift_timeout: accepted %0d bits, required %0d", i, DATA_W);
         return;
      end

      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.cipher_vld && lat < 10);
      checks++;
      if (lat !== 2) begin
         errors++;
         $display("FAIL latency: first cipher bit after %0d cycles, required 2", lat);
      end
      if (!bus.cipher_vld) return;

      cnt = 0;
      while (bus.cipher_vld && cnt < NBITS + 2) begin
         if (cnt < DATA_W) got = {got[DATA_W-2:0], bus.cipher_out};
         else              got_par = bus.cipher_out;
         checks++;
         if (bus.done !== (cnt == NBITS - 1)) begin
            errors++;
            $display("FAIL done_bit%0d: done=%b, required %b", cnt, bus.done, cnt == NBITS - 1);
         end
         checks++;
         if (bus.busy !== (cnt != NBITS - 1)) begin
            errors++;
            $display("FAIL busy_bit%0d: busy=%b, required %b", cnt, bus.busy, cnt != NBITS - 1);
         end
         if (abort_at >= 0 && cnt == abort_at - 1) begin
            rst = 1'b1;
            @(negedge clk);
            checks++;
            if ({bus.cipher_out, bus.cipher_vld, bus.busy, bus.done} !== 4'b0000) begin
               errors++;
               $display("FAIL abort_outputs: out/vld/busy/done=%b, required 0000",
                        {bus.cipher_out, bus.cipher_vld, bus.busy, bus.done});
            end
            rst   = 1'b0;
            key_m = '0;
            idx_m = 0;
            return;
         end
         if (disturb && cnt == 2) begin
            bus.start    = 1'b1;
            bus.key_load = 1'b1;
            bus.key      = ~key_m;
         end else if (disturb && cnt == 3) begin
            bus.start    = 1'b0;
            bus.key_load = 1'b0;
         end
         cnt++;
         @(negedge clk);
      end
      bus.start    = 1'b0;
      bus.key_load = 1'b0;

      checks++;
      if (cnt !== NBITS) begin
         errors++;
         $display("FAIL vld_length: %0d valid bits, required %0d", cnt, NBITS);
      end
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL word: got %h, required %h", got, exp);
      end
`ifdef SERDES_PARITY_EN
      checks++;
      if (got_par !== exp_par) begin
         errors++;
         $display("FAIL parity: got %b, required %b", got_par, exp_par);
      end
`endif
      checks++;
      if ({bus.cipher_vld, bus.done} !== 2'b00) begin
         errors++;
         $display("FAIL tail: vld/done=%b, required 00", {bus.cipher_vld, bus.done});
      end
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.a_bit    = 1'b0;
      bus.b_bit    = 1'b0;
      bus.key_load = 1'b0;
      bus.key      = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.cipher_out, bus.cipher_vld, bus.busy, bus.done} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs: out/vld/busy/done=%b, required 0000",
                  {bus.cipher_out, bus.cipher_vld, bus.busy, bus.done});
      end
      rst   = 1'b0;
      key_m = '0;
      idx_m = 0;
   endtask

   task automatic test_slices();
      logic [DATA_W-1:0] got;
      logic [DATA_W-1:0] req [5];
      req[0] = 8'hB2; req[1] = 8'hA5; req[2] = 8'hD4; req[3] = 8'hC7; req[4] = 8'hB2;
      for (int w = 0; w < 5; w++) begin
         run_word(8'h5A, 8'h3C, w == 0, 32'hA1B2C3D4, 0, 1'b0, -1, got);
         checks++;
         if (got !== req[w]) begin
            errors++;
            $display("FAIL slice_word%0d: got %h, required %h", w, got, req[w]);
         end
      end
   endtask

   task automatic test_stall();
      logic [DATA_W-1:0] got;
      run_word(8'h5A, 8'h3C, 1'b1, 32'hA1B2C3D4, 1, 1'b0, -1, got);
      checks++;
      if (got !== 8'hB2) begin
         errors++;
         $display("FAIL stall_word: got %h, required b2", got);
      end
   endtask

   task automatic test_ignore_midword();
      logic [DATA_W-1:0] got;
      // Slice 1 is next; the disturbed word must still use the loaded key.
      run_word(8'h5A, 8'h3C, 1'b0, '0, 0, 1'b1, -1, got);
      checks++;
      if (got !== 8'hA5) begin
         errors++;
         $display("FAIL ignore_word: got %h, required a5", got);
      end
   endtask

   task automatic test_midword_reset();
      logic [DATA_W-1:0] got;
      run_word(8'h5A, 8'h3C, 1'b0, '0, 0, 1'b0, 3, got);
      run_word(8'h5A, 8'h3C, 1'b0, '0, 0, 1'b0, -1, got);
      checks++;
      if (got !== 8'h66) begin
         errors++;
         $display("FAIL after_reset_word: got %h, required 66", got);
      end
   endtask

   task automatic test_parity_words();
      logic [DATA_W-1:0] got;
      run_word(8'h5A, 8'h3C, 1'b1, 32'hA1B2C3D4, 0, 1'b0, -1, got);
      checks++;
      if (got !== 8'hB2) begin
         errors++;
         $display("FAIL parity_word0: got %h, required b2", got);
      end
      run_word(8'h01, 8'h00, 1'b1, 32'hA1B2C3D4, 0, 1'b0, -1, got);
      checks++;
      if (got !== 8'hD5) begin
         errors++;
         $display("FAIL parity_word1: got %h, required d5", got);
      end
   endtask

   task automatic test_random();
      logic [DATA_W-1:0] got;
      for (int w = 0; w < 12; w++) begin
         run_word(DATA_W'($urandom), DATA_W'($urandom), ($urandom_range(0, 3) == 0),
                  KEY_W'($urandom), 2, 1'b0, -1, got);
      end
   endtask

   initial begin
      test_reset();
      test_slices();
      test_stall();
      test_ignore_midword();
      test_midword_reset();
      test_parity_words();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
